// File: rtl/qsys_sdram_cpu_oci_dtrace_pkg.sv
// Shared types and constants for the OCI data-trace packer.
package qsys_sdram_cpu_oci_dtrace_pkg;

  localparam int         SLOTS          = 15;
  localparam int         DCT_W          = 2 * SLOTS;
  localparam int         CNT_W          = 4;
  localparam logic [1:0] TW_TYPE_DTRACE = 2'b10;
  localparam int         TW_W           = 36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_EMIT,
    ST_DRAIN,
    ST_ENDED
  } dtrace_state_e;

endpackage

// File: rtl/qsys_sdram_cpu_oci_dtrace_addr.sv
// Wrapping trace-RAM write address with a sticky flag set on the all-ones -> 0 step.
module qsys_sdram_cpu_oci_dtrace_addr #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              wrapped
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr    <= '0;
      wrapped <= 1'b0;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
      if (&addr) wrapped <= 1'b1;
    end
  end

endmodule

// File: rtl/qsys_sdram_cpu_oci_dtrace_packer.sv
// Packs 2-bit trace atoms into 30-bit buffers and hands them to the trace-RAM writer.
//
// state | meaning
// IDLE  | out of reset, waiting for trace_en
// FILL  | accepting atoms into dct_buffer
// EMIT  | offering the packed word, waiting for tw_ready
// DRAIN | trace_en dropped; decide whether a partial word remains
// ENDED | drain complete, waiting for trace_en to rise again
module qsys_sdram_cpu_oci_dtrace_packer
  import qsys_sdram_cpu_oci_dtrace_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trace_en,
  input  logic              atom_valid,
  input  logic [1:0]        atom_data,
  output logic              atom_ready,
  input  logic              flush,
  output logic              tw_valid,
  output logic [TW_W-1:0]   tw_data,
  output logic [ADDR_W-1:0] tw_addr,
  input  logic              tw_ready,
  output logic              tw_wrapped,
  output logic [DCT_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_ending,
  output logic              test_has_ended
);

  dtrace_state_e      state, state_nxt;
  logic [DCT_W-1:0]   buf_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               ending_nxt, ended_nxt;
  logic               trace_en_q;
  logic               tw_hs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      dct_buffer     <= '0;
      dct_count      <= '0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
      trace_en_q     <= 1'b0;
    end else begin
      state          <= state_nxt;
      dct_buffer     <= buf_nxt;
      dct_count      <= cnt_nxt;
      test_ending    <= ending_nxt;
      test_has_ended <= ended_nxt;
      trace_en_q     <= trace_en;
    end
  end

  always_comb begin
    state_nxt  = state;
    buf_nxt    = dct_buffer;
    cnt_nxt    = dct_count;
    ending_nxt = test_ending;
    ended_nxt  = test_has_ended;
    unique case (state)
      ST_IDLE: begin
        if (trace_en) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        // Slots above the fill point are zero, so OR-ing in place is enough.
        if (atom_valid) begin
          buf_nxt = dct_buffer | (DCT_W'(atom_data) << {dct_count, 1'b0});
          cnt_nxt = dct_count + 4'd1;
        end
        if (!trace_en) begin
          state_nxt  = ST_DRAIN;
          ending_nxt = 1'b1;
        end else if (cnt_nxt == CNT_W'(SLOTS) || (flush && cnt_nxt != '0)) begin
          state_nxt = ST_EMIT;
        end
      end
      ST_DRAIN: begin
        if (dct_count != '0) begin
          state_nxt = ST_EMIT;
        end else begin
          state_nxt  = ST_ENDED;
          ending_nxt = 1'b0;
          ended_nxt  = 1'b1;
        end
      end
      ST_EMIT: begin
        if (!trace_en) ending_nxt = 1'b1;
        if (tw_ready) begin
          buf_nxt = '0;
          cnt_nxt = '0;
          if (ending_nxt) begin
            state_nxt  = ST_ENDED;
            ending_nxt = 1'b0;
            ended_nxt  = 1'b1;
          end else begin
            state_nxt = ST_FILL;
          end
        end
      end
      ST_ENDED: begin
        if (trace_en && !trace_en_q) begin
          state_nxt = ST_FILL;
          ended_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign atom_ready = (state == ST_FILL);
  assign tw_valid   = (state == ST_EMIT);
  assign tw_data    = {TW_TYPE_DTRACE, dct_count, dct_buffer};
  assign tw_hs      = tw_valid && tw_ready;

  qsys_sdram_cpu_oci_dtrace_addr #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (tw_hs),
    .addr    (tw_addr),
    .wrapped (tw_wrapped)
  );

endmodule

// File: tb/tb_qsys_sdram_cpu_oci_dtrace_packer.sv
// Directed-plus-random bench for the data-trace packer against a queue-based model.
module tb_qsys_sdram_cpu_oci_dtrace_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trace_en;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        flush;
  logic        tw_valid;
  logic [35:0] tw_data;
  logic [6:0]  tw_addr;
  logic        tw_ready;
  logic        tw_wrapped;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  int tests  = 0;
  int failed = 0;
  int hs     = 0;
  logic [1:0] mq[$];

  always #5 clk = ~clk;

  qsys_sdram_cpu_oci_dtrace_packer #(.ADDR_W(7)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trace_en       (trace_en),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .tw_valid       (tw_valid),
    .tw_data        (tw_data),
    .tw_addr        (tw_addr),
    .tw_ready       (tw_ready),
    .tw_wrapped     (tw_wrapped),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  // Reference: atom i sits at weight 4**i; word header is type 2'b10 then count.
  function automatic logic [29:0] exp_buf();
    longint acc = 0;
    longint w   = 1;
    foreach (mq[i]) begin
      acc = acc + longint'(mq[i]) * w;
      w   = w * 4;
    end
    return acc[29:0];
  endfunction

  function automatic logic [35:0] exp_word();
    logic [3:0] n = 4'(mq.size());
    return {2'b10, n, exp_buf()};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] v);
    atom_valid = 1'b1;
    atom_data  = v;
    step();
    atom_valid = 1'b0;
    mq.push_back(v);
    chk("count", dct_count, mq.size());
    chk("buffer", dct_buffer, exp_buf());
  endtask

  task automatic feed(input int n, input bit gaps);
    int got   = 0;
    int guard = 0;
    while (got < n && guard < 200) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        atom_valid = 1'b0;
        step();
        chk("idle_count", dct_count, mq.size());
      end else begin
        put(2'($urandom));
        got++;
      end
    end
    if (got != n) chk("feed_budget", got, n);
  endtask

  task automatic emit(input int stall, input logic ready_after);
    logic [35:0] w = exp_word();
    chk("emit_valid", tw_valid, 1);
    chk("emit_data", tw_data, w);
    chk("emit_addr", tw_addr, hs % 128);
    chk("emit_ready_low", atom_ready, 0);
    for (int i = 0; i < stall; i++) begin
      atom_valid = 1'b1;
      atom_data  = 2'($urandom);
      step();
      chk("stall_valid", tw_valid, 1);
      chk("stall_data", tw_data, w);
      chk("stall_addr", tw_addr, hs % 128);
      chk("stall_count", dct_count, mq.size());
    end
    atom_valid = 1'b0;
    tw_ready   = 1'b1;
    step();
    tw_ready = 1'b0;
    hs++;
    mq.delete();
    chk("hs_valid", tw_valid, 0);
    chk("hs_count", dct_count, 0);
    chk("hs_buffer", dct_buffer, 0);
    chk("hs_addr", tw_addr, hs % 128);
    chk("hs_wrapped", tw_wrapped, (hs >= 128) ? 1 : 0);
    chk("hs_atom_ready", atom_ready, ready_after);
  endtask

  initial begin
    reset_n    = 1'b0;
    trace_en   = 1'b0;
    atom_valid = 1'b0;
    atom_data  = 2'b00;
    flush      = 1'b0;
    tw_ready   = 1'b0;
    #12;
    chk("rst_outputs", {atom_ready, tw_valid, tw_data, tw_addr, tw_wrapped,
                        dct_buffer, dct_count, test_ending, test_has_ended}, 0);
    reset_n = 1'b1;
    step();
    chk("idle_ready", atom_ready, 0);
    trace_en = 1'b1;
    step();
    chk("fill_ready", atom_ready, 1);

    // 15 atoms of 2'b01 back to back
    for (int i = 0; i < 15; i++) put(2'b01);
    emit(0, 1);

    // Random full words with random gaps and writer stalls
    for (int k = 0; k < 4; k++) begin
      feed(15, 1'b1);
      emit($urandom_range(0, 5), 1);
    end

    // Partial word 3,2,1 then flush; flush at count 0 is ignored
    put(2'd3);
    put(2'd2);
    put(2'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", dct_count, 3);
    emit(0, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush0_valid", tw_valid, 0);
    chk("flush0_ready", atom_ready, 1);

    // Random partial with flush, writer stalled 5 cycles
    feed($urandom_range(1, 14), 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    emit(5, 1);

    // Run until the address has wrapped
    while (hs < 128) begin
      feed(15, 1'b0);
      emit(0, 1);
    end
    chk("wrap_addr", tw_addr, 0);
    chk("wrap_flag", tw_wrapped, 1);

    // Drain with 7 atoms buffered
    feed(7, 1'b0);
    trace_en = 1'b0;
    step();
    chk("drain_ending", test_ending, 1);
    chk("drain_count", dct_count, 7);
    chk("drain_valid", tw_valid, 0);
    step();
    chk("drain_emit_ending", test_ending, 1);
    emit(0, 0);
    chk("ended_ending", test_ending, 0);
    chk("ended_flag", test_has_ended, 1);

    // Restart, then drain with empty buffer
    trace_en = 1'b1;
    step();
    chk("restart_flag", test_has_ended, 0);
    chk("restart_ready", atom_ready, 1);
    trace_en = 1'b0;
    step();
    chk("drain0_ending", test_ending, 1);
    chk("drain0_valid", tw_valid, 0);
    step();
    chk("ended0_flag", test_has_ended, 1);
    chk("ended0_valid", tw_valid, 0);
    chk("ended0_addr", tw_addr, hs % 128);

    // Reset asserted mid-EMIT
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 15; i++) put(2'($urandom));
    chk("pre_rst_valid", tw_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {atom_ready, tw_valid, tw_addr, tw_wrapped,
                            dct_buffer, dct_count, test_ending, test_has_ended}, 0);
    trace_en = 1'b0;
    mq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    chk("post_rst_idle", atom_ready, 0);
    chk("post_rst_addr", tw_addr, 0);
    chk("post_rst_valid", tw_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
